// File: rtl/pmul_pkg.sv
// Shared stage type and rescale/saturate helper for pipelined_multiplier.
// Define PMUL_ROUND_EN for round-half-up rescaling; default build truncates.
package pmul_pkg;

  localparam int unsigned PmulWidth    = 16;
  localparam int unsigned PmulFracBits = 8;
  localparam int unsigned AccWidth     = 2 * PmulWidth;

  typedef struct packed {
    logic                 valid;
    logic [AccWidth-1:0]  acc;
    logic [AccWidth-1:0]  a_sh;
    logic [PmulWidth-1:0] b;
  } pmul_stage_t;

  // Returns {overflow, product} for a full-width product p.
  function automatic logic [PmulWidth:0] sat_shift(input logic [AccWidth-1:0] p,
                                                   input int unsigned         frac_bits);
    logic [AccWidth:0] s;
`ifdef PMUL_ROUND_EN
    logic [AccWidth:0] bias;
    // Half an LSB of the result; collapses to zero when frac_bits is 0.
    bias = ((AccWidth+1)'(1) << frac_bits) >> 1;
    s    = ({1'b0, p} + bias) >> frac_bits;
`else
    s    = {1'b0, p} >> frac_bits;
`endif
    if (s[AccWidth:PmulWidth] != '0) begin
      sat_shift = {1'b1, {PmulWidth{1'b1}}};
    end else begin
      sat_shift = {1'b0, s[PmulWidth-1:0]};
    end
  endfunction

endpackage

// File: rtl/pmul_stage.sv
// One shift-add stage: adds the aligned multiplicand when multiplier bit Idx-1 is set.
// All fields hold while adv_i is low.
module pmul_stage
  import pmul_pkg::*;
#(
  parameter int unsigned Idx = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 adv_i,
  input  logic                 valid_i,
  input  logic [AccWidth-1:0]  acc_i,
  input  logic [AccWidth-1:0]  a_sh_i,
  input  logic [PmulWidth-1:0] b_i,
  output logic                 valid_o,
  output logic [AccWidth-1:0]  acc_o,
  output logic [AccWidth-1:0]  a_sh_o,
  output logic [PmulWidth-1:0] b_o
);

  pmul_stage_t stage_d, stage_q;

  always_comb begin
    stage_d.valid = valid_i;
    stage_d.acc   = acc_i;
    stage_d.a_sh  = a_sh_i << 1;
    stage_d.b     = b_i;
    if (b_i[Idx-1]) begin
      stage_d.acc = acc_i + a_sh_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else if (adv_i) begin
      stage_q <= stage_d;
    end
  end

  assign valid_o = stage_q.valid;
  assign acc_o   = stage_q.acc;
  assign a_sh_o  = stage_q.a_sh;
  assign b_o     = stage_q.b;

endmodule

// File: rtl/pipelined_multiplier.sv
// Fully pipelined unsigned fixed-point multiplier, one stage per multiplier bit.
// WIDTH must match pmul_pkg::PmulWidth; PMUL_ROUND_EN selects rounding in pmul_pkg.
module pipelined_multiplier
  import pmul_pkg::*;
#(
  parameter int unsigned WIDTH     = PmulWidth,
  parameter int unsigned FRAC_BITS = PmulFracBits
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] product_o,
  output logic             overflow_o
);

  logic                 adv;
  logic [WIDTH:0]       valid_p;
  logic [2*WIDTH-1:0]   acc_p  [WIDTH+1];
  logic [2*WIDTH-1:0]   a_sh_p [WIDTH+1];
  logic [WIDTH-1:0]     b_p    [WIDTH+1];
  logic [WIDTH:0]       res;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     product_q;
  logic                 overflow_q;

  // The whole pipe moves together; it only stalls when a result is blocked at the output.
  assign adv        = !out_valid_q || out_ready_i;
  assign in_ready_o = adv;

  assign valid_p[0] = in_valid_i;
  assign acc_p[0]   = '0;
  assign a_sh_p[0]  = {{WIDTH{1'b0}}, a_i};
  assign b_p[0]     = b_i;

  for (genvar i = 1; i <= WIDTH; i++) begin : g_stage
    pmul_stage #(
      .Idx(i)
    ) u_stage (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .adv_i  (adv),
      .valid_i(valid_p[i-1]),
      .acc_i  (acc_p[i-1]),
      .a_sh_i (a_sh_p[i-1]),
      .b_i    (b_p[i-1]),
      .valid_o(valid_p[i]),
      .acc_o  (acc_p[i]),
      .a_sh_o (a_sh_p[i]),
      .b_o    (b_p[i])
    );
  end

  assign res = sat_shift(acc_p[WIDTH], FRAC_BITS);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      product_q   <= '0;
      overflow_q  <= 1'b0;
    end else if (adv) begin
      out_valid_q <= valid_p[WIDTH];
      if (valid_p[WIDTH]) begin
        {overflow_q, product_q} <= res;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign product_o   = product_q;
  assign overflow_o  = overflow_q;

  // The last stage's operand copies have no consumer.
  logic unused_tail;
  assign unused_tail = ^{a_sh_p[WIDTH], b_p[WIDTH]};

endmodule
